pipeline_sequencer: RTL and testbench
=====================================

// Module: pipeline_sequencer
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Merges load-use freeze, multi-cycle EX busy
//  and EX-stage branch redirect into per-register enable/flush controls, and adds a debug
//  halt/step/resume FSM that drains the pipeline before reporting halted. Sits beside the hazard
//  unit and drives PC, IF/ID, ID/EX and EX/MEM registers.
// PARAMETERS
//  DRAIN_CYCLES  4  stall-free cycles needed to empty IF..WB after fetch stops (>=1)
// PORTS
//  clk_i              in   1  clock (one clock domain)
//  rst_i              in   1  synchronous reset, active-high
//  load_use_i         in   1  load-use hazard (hazard unit freeze)
//  ex_busy_i          in   1  multi-cycle EX op not finished
//  branch_taken_ex_i  in   1  taken branch/jump resolved in EX
//  halt_req_i         in   1  debug halt request (level, sampled each cycle)
//  resume_req_i       in   1  debug resume (pulse)
//  step_req_i         in   1  debug single-step (pulse)
//  pc_en_o            out  1  PC register load enable
//  if_id_en_o         out  1  IF/ID load enable
//  if_id_flush_o      out  1  IF/ID loads NOP
//  id_ex_flush_o      out  1  ID/EX loads bubble
//  id_ex_en_o         out  1  ID/EX load enable
//  ex_mem_flush_o     out  1  EX/MEM loads bubble
//  halted_o           out  1  core halted, pipeline empty
//  state_o            out  2  FSM state (debug visibility)
// BEHAVIOUR
//  - Reset: state=RUN, drain_cnt=0. While rst_i=1: all *_en_o=0, all *_flush_o=1, halted_o=0.
//  - Outputs combinational from state + inputs (0-cycle latency); state/counter change on clk_i edge.
//  - Stall priority (RUN, DRAIN, STEP): ex_busy > branch_taken > load_use > none.
//    ex_busy:  pc_en=0 if_id_en=0 id_ex_en=0 ex_mem_flush=1; branch/load_use ignored that cycle.
//    branch:   pc_en=1 if_id_flush=1 id_ex_flush=1 (squashes load-use victim; no stall).
//    load_use: pc_en=0 if_id_en=0 id_ex_flush=1.
//    none:     pc_en=1 if_id_en=1 id_ex_en=1, no flushes.
//  - Flush outputs take precedence over enables on the same register (flush implies load).
//  - States: RUN(0) DRAIN(1) HALTED(2) STEP(3).
//  - RUN: halt_req_i=1 -> DRAIN, drain_cnt<=DRAIN_CYCLES. Never blocked by stalls.
//  - DRAIN: fetch stopped: if_id_flush=1 every cycle unless load_use/ex_busy holds IF/ID;
//    pc_en=1 only on branch_taken (PC keeps redirect target for resume), else 0.
//    drain_cnt decrements only in cycles with ex_busy=0 and load_use=0; branch does not reload it.
//    drain_cnt==1 and decrementing -> HALTED. resume/step/halt ignored.
//  - HALTED: halted_o=1, pc_en=0, all enables 0, no flushes (registers hold bubbles).
//    resume_req_i -> RUN; step_req_i -> STEP; both in same cycle: resume wins.
//    halt_req_i still high on resume: RUN for exactly one cycle then DRAIN.
//  - STEP: exactly one cycle, normal RUN priority rules (one fetch unless stalled);
//    -> DRAIN with drain_cnt<=DRAIN_CYCLES regardless of stall; halt_req ignored.
//    Stalled step: instruction stays in IF/ID and completes during DRAIN.
//  - drain_cnt width $clog2(DRAIN_CYCLES+1); never wraps (no decrement at 0).
//  - Reset mid-DRAIN/STEP: immediate return to RUN; in-flight drain discarded.
// STRUCTURE
//  - pipeline_ctrl_pkg: typedef enum logic [1:0] seq_state_e {RUN,DRAIN,HALTED,STEP};
//    typedef struct packed pipe_ctrl_t {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_flush}.
//  - Sub-module stall_priority_encoder (comb): ex_busy/branch/load_use -> pipe_ctrl_t; FSM overlays
//    DRAIN/HALTED masking on its output.
// TESTING
//  1 Reset: rst_i=1 two cycles -> flushes=1, enables=0, state_o=0; release -> pc_en_o=1.
//  2 load_use=1 & branch_taken=1 same cycle -> pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_en=0.
//  3 ex_busy=1 for 3 cycles with load_use=1 -> pc/if_id/id_ex en=0, ex_mem_flush=1 for all 3.
//  4 halt_req pulse in RUN, no stalls -> DRAIN 4 cycles, halted_o=1 on 5th; with 2 load_use cycles
//    inside drain -> halted_o on 7th.
//  5 HALTED, step_req -> STEP 1 cycle pc_en=1, then DRAIN 4, halted_o=1; resume+step same
//    cycle -> state_o=0 next.
//  6 Branch taken during DRAIN -> pc_en=1 that cycle only, count unaffected; rst_i mid-DRAIN -> RUN.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } seq_state_e;

    // Per-register controls. A flush bit means the register loads a NOP/bubble,
    // so a set flush makes the matching enable irrelevant.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/stall_priority_encoder.sv
// Resolves simultaneous hazards into one set of register controls.
// Priority: EX busy > taken branch > load-use > free-running.
module stall_priority_encoder
    import pipeline_ctrl_pkg::*;
(
    input  logic       ex_busy_i,
    input  logic       branch_taken_i,
    input  logic       load_use_i,
    output pipe_ctrl_t ctrl_o
);

    // Pick the winning hazard and emit its controls.
    always_comb begin
        ctrl_o = '0;
        if (ex_busy_i) begin
            // Freeze the front end; EX/MEM takes bubbles until EX completes.
            ctrl_o.ex_mem_flush = 1'b1;
        end else if (branch_taken_i) begin
            // Redirect wins over load-use: the stalled instruction is wrong-path anyway.
            ctrl_o.pc_en       = 1'b1;
            ctrl_o.if_id_flush = 1'b1;
            ctrl_o.id_ex_flush = 1'b1;
        end else if (load_use_i) begin
            ctrl_o.id_ex_flush = 1'b1;
        end else begin
            ctrl_o.pc_en    = 1'b1;
            ctrl_o.if_id_en = 1'b1;
            ctrl_o.id_ex_en = 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer with debug halt/step/resume; drains the pipeline
// before reporting halted.
//
//  state  | meaning
//  RUN    | normal execution, hazard controls pass straight through
//  DRAIN  | fetch stopped, counting stall-free cycles until the pipe is empty
//  HALTED | pipe empty, all registers hold, waiting for resume/step
//  STEP   | one normal cycle (single fetch) then back to DRAIN
module pipeline_sequencer
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_use_i,
    input  logic       ex_busy_i,
    input  logic       branch_taken_ex_i,
    input  logic       halt_req_i,
    input  logic       resume_req_i,
    input  logic       step_req_i,
    output logic       pc_en_o,
    output logic       if_id_en_o,
    output logic       if_id_flush_o,
    output logic       id_ex_flush_o,
    output logic       id_ex_en_o,
    output logic       ex_mem_flush_o,
    output logic       halted_o,
    output logic [1:0] state_o
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    pipe_ctrl_t    base_ctrl, ctrl;
    logic          halted;

    stall_priority_encoder u_prio (
        .ex_busy_i      (ex_busy_i),
        .branch_taken_i (branch_taken_ex_i),
        .load_use_i     (load_use_i),
        .ctrl_o         (base_ctrl)
    );

    // State and drain counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next state and per-state masking of the hazard controls.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        ctrl        = base_ctrl;
        halted      = 1'b0;
        unique case (state_q)
            RUN: begin
                if (halt_req_i) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                // No new fetches: whenever IF/ID would load, it loads a NOP instead.
                ctrl.if_id_flush = base_ctrl.if_id_en | base_ctrl.if_id_flush;
                ctrl.if_id_en    = 1'b0;
                // PC only moves to capture a redirect so resume restarts at the target.
                ctrl.pc_en       = branch_taken_ex_i & ~ex_busy_i;
                if (!ex_busy_i && !load_use_i && drain_cnt_q != '0) begin
                    drain_cnt_d = drain_cnt_q - CW'(1);
                    if (drain_cnt_q == CW'(1)) state_d = HALTED;
                end
            end
            HALTED: begin
                ctrl   = '0;
                halted = 1'b1;
                if (resume_req_i)    state_d = RUN;
                else if (step_req_i) state_d = STEP;
            end
            STEP: begin
                state_d     = DRAIN;
                drain_cnt_d = DRAIN_LOAD;
            end
            default: state_d = RUN;
        endcase
    end

    // Reset forces every register to take bubbles regardless of state.
    always_comb begin
        if (rst_i) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_en_o     = 1'b0;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            halted_o       = 1'b0;
            state_o        = 2'(RUN);
        end else begin
            pc_en_o        = ctrl.pc_en;
            if_id_en_o     = ctrl.if_id_en;
            if_id_flush_o  = ctrl.if_id_flush;
            id_ex_en_o     = ctrl.id_ex_en;
            id_ex_flush_o  = ctrl.id_ex_flush;
            ex_mem_flush_o = ctrl.ex_mem_flush;
            halted_o       = halted;
            state_o        = state_q;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench: behavioural reference model compared every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_pipeline_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst, lu, busy, br, halt, res, stp;
    logic       pc_en, ifid_en, ifid_fl, idex_fl, idex_en, exmem_fl, halted;
    logic [1:0] st;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0=RUN 1=DRAIN 2=HALTED 3=STEP, 'left' = stall-free cycles still owed.
    int m_mode = 0;
    int m_left = 0;

    always #5 clk = ~clk;

    pipeline_sequencer #(.DRAIN_CYCLES(N)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .load_use_i        (lu),
        .ex_busy_i         (busy),
        .branch_taken_ex_i (br),
        .halt_req_i        (halt),
        .resume_req_i      (res),
        .step_req_i        (stp),
        .pc_en_o           (pc_en),
        .if_id_en_o        (ifid_en),
        .if_id_flush_o     (ifid_fl),
        .id_ex_flush_o     (idex_fl),
        .id_ex_en_o        (idex_en),
        .ex_mem_flush_o    (exmem_fl),
        .halted_o          (halted),
        .state_o           (st)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs as {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, halted}.
    function automatic logic [6:0] model_out();
        logic [6:0] e;
        if (rst)             return 7'b0010110;
        if (m_mode == 2)     return 7'b0000001;
        if (busy)            e = 7'b0000010;
        else if (br)         e = 7'b1010100;
        else if (lu)         e = 7'b0000100;
        else                 e = 7'b1101000;
        if (m_mode == 1) begin
            e[6] = br && !busy;                  // PC only follows a redirect
            e[5] = 1'b0;                         // no fetch into IF/ID
            e[4] = !(busy || (lu && !br));       // NOP unless IF/ID is held
        end
        return e;
    endfunction

    function automatic int model_state();
        return rst ? 0 : m_mode;
    endfunction

    task automatic model_advance();
        if (rst) begin
            m_mode = 0; m_left = 0;
        end else if (m_mode == 0) begin
            if (halt) begin m_mode = 1; m_left = N; end
        end else if (m_mode == 1) begin
            if (!busy && !lu && m_left > 0) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end else if (m_mode == 2) begin
            if (res) m_mode = 0;
            else if (stp) m_mode = 3;
        end else begin
            m_mode = 1; m_left = N;
        end
    endtask

    // Drive one cycle's inputs on the falling edge, settle, compare with the model.
    task automatic apply(input logic r, input logic l, input logic b, input logic j,
                         input logic h, input logic rs, input logic s);
        logic [6:0] e;
        @(negedge clk);
        rst = r; lu = l; busy = b; br = j; halt = h; res = rs; stp = s;
        #1;
        e = model_out();
        chk("model_outputs", int'({pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_fl, halted}), int'(e));
        chk("model_state", int'(st), model_state());
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Drive idle cycles (optionally load-use on chosen cycles) until halted_o; return the cycle index.
    task automatic count_to_halt(input int lu_a, input int lu_b, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            apply(0, (i == lu_a) || (i == lu_b), 0, 0, 0, 0, 0);
            if (halted) begin n = i; break; end
            tick();
        end
    endtask

    int n;

    initial begin
        rst = 1; lu = 0; busy = 0; br = 0; halt = 0; res = 0; stp = 0;

        // 1: reset
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 0, 0, 0, 0, 0);
            chk("rst_flushes", int'({ifid_fl, idex_fl, exmem_fl}), 7);
            chk("rst_enables", int'({pc_en, ifid_en, idex_en}), 0);
            chk("rst_state", int'(st), 0);
            tick();
        end
        idle();
        chk("post_rst_pc_en", int'(pc_en), 1);
        tick();

        // 2: branch overrides load-use
        apply(0, 1, 0, 1, 0, 0, 0);
        chk("br_lu_ctrl", int'({pc_en, ifid_fl, idex_fl, ifid_en}), 4'b1110);
        tick();

        // 3: ex_busy dominates load-use
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 1, 0, 0, 0, 0);
            chk("busy_ctrl", int'({pc_en, ifid_en, idex_en, exmem_fl}), 4'b0001);
            tick();
        end

        // 4: halt with clean drain, then with two load-use cycles inside
        apply(0, 0, 0, 0, 1, 0, 0); tick();
        count_to_halt(0, 0, n);
        chk("drain_clean_len", n, 5);
        tick();
        apply(0, 0, 0, 0, 0, 1, 0); tick();
        apply(0, 0, 0, 0, 1, 0, 0); tick();
        count_to_halt(2, 3, n);
        chk("drain_lu_len", n, 7);
        tick();

        // 5: single step, then resume+step together
        apply(0, 0, 0, 0, 0, 0, 1); tick();
        idle();
        chk("step_state", int'(st), 3);
        chk("step_pc_en", int'(pc_en), 1);
        tick();
        count_to_halt(0, 0, n);
        chk("step_drain_len", n, 5);
        tick();
        apply(0, 0, 0, 0, 0, 1, 1); tick();
        idle();
        chk("resume_wins", int'(st), 0);
        tick();

        // 6: branch during drain, then reset mid-drain
        apply(0, 0, 0, 0, 1, 0, 0); tick();
        apply(0, 0, 0, 1, 0, 0, 0);
        chk("drain_br_pc_en", int'(pc_en), 1);
        tick();
        idle();
        chk("drain_nobr_pc_en", int'(pc_en), 0);
        chk("drain_state", int'(st), 1);
        tick();
        apply(1, 0, 0, 0, 0, 0, 0); tick();
        idle();
        chk("rst_mid_drain", int'(st), 0);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
                  $urandom_range(5) == 0, $urandom_range(9) == 0, $urandom_range(7) == 0,
                  $urandom_range(7) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
